// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM pipeline register.
// Also flags load-use hazards against the instruction sitting in ID.
module ex_stage #(
    parameter int D_WIDTH = 32,
    parameter int N_REGS  = 32,
    parameter int RF_SIZE = $clog2(N_REGS),
    parameter int OP_SIZE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               bubble,
    input  logic [RF_SIZE-1:0] rs1_ex,
    input  logic [RF_SIZE-1:0] rs2_ex,
    input  logic [D_WIDTH-1:0] rs1_val_ex,
    input  logic [D_WIDTH-1:0] rs2_val_ex,
    input  logic [D_WIDTH-1:0] imm_ex,
    input  logic [RF_SIZE-1:0] rd_ex,
    input  logic               reg_write_ex,
    input  logic               alu_src_imm_ex,
    input  logic [OP_SIZE-1:0] alu_op_ex,
    input  logic               mem_we_ex,
    input  logic               mem_re_ex,
    input  logic               mem_to_reg_ex,
    input  logic [RF_SIZE-1:0] id_rs1,
    input  logic [RF_SIZE-1:0] id_rs2,
    input  logic               wb_we,
    input  logic [RF_SIZE-1:0] wb_rd,
    input  logic [D_WIDTH-1:0] wb_data,
    output logic [D_WIDTH-1:0] alu_result_mem,
    output logic [D_WIDTH-1:0] store_data_mem,
    output logic [RF_SIZE-1:0] rd_mem,
    output logic               reg_write_mem,
    output logic               mem_we_mem,
    output logic               mem_re_mem,
    output logic               mem_to_reg_mem,
    output logic               load_use_stall
);

    // A MEM-stage load holds only an address, so it is never a forward source.
    logic mem_fwd_ok;
    logic wb_fwd_ok;
    logic [D_WIDTH-1:0] op_a;
    logic [D_WIDTH-1:0] rs2_fwd;
    logic [D_WIDTH-1:0] op_b;
    logic [D_WIDTH-1:0] alu_res;

    assign mem_fwd_ok = reg_write_mem && !mem_to_reg_mem && (rd_mem != '0);
    assign wb_fwd_ok  = wb_we && (wb_rd != '0);

    // Forward mux per source: MEM result first, then WB data, else RF.
    always_comb begin
        op_a    = rs1_val_ex;
        rs2_fwd = rs2_val_ex;
        if (mem_fwd_ok && (rd_mem == rs1_ex))
            op_a = alu_result_mem;
        else if (wb_fwd_ok && (wb_rd == rs1_ex))
            op_a = wb_data;
        if (mem_fwd_ok && (rd_mem == rs2_ex))
            rs2_fwd = alu_result_mem;
        else if (wb_fwd_ok && (wb_rd == rs2_ex))
            rs2_fwd = wb_data;
    end

    assign op_b = alu_src_imm_ex ? imm_ex : rs2_fwd;

    // ALU; unknown op codes produce zero.
    always_comb begin
        alu_res = '0;
        case (alu_op_ex)
            OP_SIZE'(0): alu_res = op_a + op_b;
            OP_SIZE'(1): alu_res = op_a - op_b;
            OP_SIZE'(2): alu_res = op_a & op_b;
            OP_SIZE'(3): alu_res = op_a | op_b;
            OP_SIZE'(4): alu_res = op_a ^ op_b;
            OP_SIZE'(5): alu_res = ($signed(op_a) < $signed(op_b))
                                   ? D_WIDTH'(1) : '0;
            default:     alu_res = '0;
        endcase
    end

    // Stall when a load in EX writes a register the ID instruction reads.
    assign load_use_stall = mem_re_ex && (rd_ex != '0) &&
                            ((rd_ex == id_rs1) || (rd_ex == id_rs2));

    // EX/MEM register: reset, then bubble, then advance, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            alu_result_mem <= '0;
            store_data_mem <= '0;
            rd_mem         <= '0;
            reg_write_mem  <= 1'b0;
            mem_we_mem     <= 1'b0;
            mem_re_mem     <= 1'b0;
            mem_to_reg_mem <= 1'b0;
        end else if (en) begin
            alu_result_mem <= alu_res;
            store_data_mem <= rs2_fwd;
            rd_mem         <= rd_ex;
            reg_write_mem  <= reg_write_ex;
            mem_we_mem     <= mem_we_ex;
            mem_re_mem     <= mem_re_ex;
            mem_to_reg_mem <= mem_to_reg_ex;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: ordered vector table driven one cycle per row,
// expected EX/MEM contents queued at drive time and checked after the edge.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, en, bubble;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex, id_rs1, id_rs2, wb_rd;
    logic [31:0] rs1_val_ex, rs2_val_ex, imm_ex, wb_data;
    logic        reg_write_ex, alu_src_imm_ex, mem_we_ex, mem_re_ex;
    logic        mem_to_reg_ex, wb_we;
    logic [3:0]  alu_op_ex;
    logic [31:0] alu_result_mem, store_data_mem;
    logic [4:0]  rd_mem;
    logic        reg_write_mem, mem_we_mem, mem_re_mem, mem_to_reg_mem;
    logic        load_use_stall;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bubble(bubble),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rs1_val_ex(rs1_val_ex), .rs2_val_ex(rs2_val_ex),
        .imm_ex(imm_ex), .rd_ex(rd_ex), .reg_write_ex(reg_write_ex),
        .alu_src_imm_ex(alu_src_imm_ex), .alu_op_ex(alu_op_ex),
        .mem_we_ex(mem_we_ex), .mem_re_ex(mem_re_ex),
        .mem_to_reg_ex(mem_to_reg_ex), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .alu_result_mem(alu_result_mem), .store_data_mem(store_data_mem),
        .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
        .mem_we_mem(mem_we_mem), .mem_re_mem(mem_re_mem),
        .mem_to_reg_mem(mem_to_reg_mem), .load_use_stall(load_use_stall)
    );

    typedef struct {
        logic        rst_n, en, bubble;
        logic [4:0]  rs1, rs2, rd, id_rs1, id_rs2, wb_rd;
        logic [31:0] v1, v2, imm, wb_data;
        logic        rw, src_imm, we, re, m2r, wb_we;
        logic [3:0]  op;
        logic [31:0] e_res, e_sd;
        logic [4:0]  e_rd;
        logic        e_rw, e_we, e_re, e_m2r, e_stall;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    vec_t v;

    // Register-register op that writes rd, with the expected EX/MEM result.
    function automatic vec_t rr(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] v1, input logic [31:0] v2,
                                input logic [4:0] rd, input logic [3:0] op,
                                input logic [31:0] er, input logic [31:0] es);
        vec_t r;
        r = '{default: '0};
        r.rst_n = 1'b1; r.en = 1'b1;
        r.rs1 = rs1; r.rs2 = rs2; r.v1 = v1; r.v2 = v2;
        r.rd = rd; r.op = op; r.rw = 1'b1;
        r.e_res = er; r.e_sd = es; r.e_rd = rd; r.e_rw = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one row, check the stall request, clock, then check EX/MEM.
    task automatic apply(input vec_t r, input int idx);
        vec_t e;
        rst_n = r.rst_n; en = r.en; bubble = r.bubble;
        rs1_ex = r.rs1; rs2_ex = r.rs2;
        rs1_val_ex = r.v1; rs2_val_ex = r.v2; imm_ex = r.imm;
        rd_ex = r.rd; reg_write_ex = r.rw; alu_src_imm_ex = r.src_imm;
        alu_op_ex = r.op; mem_we_ex = r.we; mem_re_ex = r.re;
        mem_to_reg_ex = r.m2r; id_rs1 = r.id_rs1; id_rs2 = r.id_rs2;
        wb_we = r.wb_we; wb_rd = r.wb_rd; wb_data = r.wb_data;
        exp_q.push_back(r);
        #1;
        chk($sformatf("row%0d stall", idx), 32'(load_use_stall),
            32'(r.e_stall));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("row%0d alu_result", idx), alu_result_mem, e.e_res);
        chk($sformatf("row%0d store_data", idx), store_data_mem, e.e_sd);
        chk($sformatf("row%0d rd", idx), 32'(rd_mem), 32'(e.e_rd));
        chk($sformatf("row%0d reg_write", idx), 32'(reg_write_mem),
            32'(e.e_rw));
        chk($sformatf("row%0d mem_we", idx), 32'(mem_we_mem), 32'(e.e_we));
        chk($sformatf("row%0d mem_re", idx), 32'(mem_re_mem), 32'(e.e_re));
        chk($sformatf("row%0d mem_to_reg", idx), 32'(mem_to_reg_mem),
            32'(e.e_m2r));
    endtask

    function automatic vec_t zero_exp(input vec_t r);
        vec_t z;
        z = r;
        z.e_res = '0; z.e_sd = '0; z.e_rd = '0;
        z.e_rw = 1'b0; z.e_we = 1'b0; z.e_re = 1'b0; z.e_m2r = 1'b0;
        return z;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset with busy inputs, two cycles
        v = zero_exp(rr(1, 2, 5, 7, 3, 0, 0, 0));
        v.rst_n = 0; v.bubble = 0; v.we = 1; v.m2r = 1;
        tbl.push_back(v);
        tbl.push_back(v);
        // add 5+7 -> x3
        tbl.push_back(rr(1, 2, 5, 7, 3, 0, 12, 7));
        // sub x3(MEM=12) - 2
        tbl.push_back(rr(3, 2, 0, 2, 6, 1, 10, 2));
        // result into x0
        tbl.push_back(rr(1, 2, 20, 30, 0, 0, 50, 30));
        // rd_mem=0 must not forward to rs1=0
        tbl.push_back(rr(0, 2, 0, 2, 7, 1, 32'hFFFF_FFFE, 2));
        // x4 = 50 in EX/MEM
        tbl.push_back(rr(1, 2, 20, 30, 4, 0, 50, 30));
        // MEM beats WB on x4: 50+1
        v = rr(4, 0, 0, 0, 8, 0, 51, 0);
        v.src_imm = 1; v.imm = 1;
        v.wb_we = 1; v.wb_rd = 4; v.wb_data = 100;
        tbl.push_back(v);
        // load-like x4 in EX/MEM (mem_to_reg)
        v = rr(1, 2, 50, 0, 4, 0, 50, 0);
        v.re = 1; v.m2r = 1; v.e_re = 1; v.e_m2r = 1;
        tbl.push_back(v);
        // MEM blocked, WB 100+1
        v = rr(4, 0, 0, 0, 9, 0, 101, 0);
        v.src_imm = 1; v.imm = 1;
        v.wb_we = 1; v.wb_rd = 4; v.wb_data = 100;
        tbl.push_back(v);
        // load-use: rd 5 vs id_rs2 5
        v = rr(1, 0, 32'h1000, 0, 5, 0, 32'h1004, 0);
        v.src_imm = 1; v.imm = 4;
        v.re = 1; v.m2r = 1; v.e_re = 1; v.e_m2r = 1;
        v.id_rs2 = 5; v.e_stall = 1;
        tbl.push_back(v);
        v.id_rs1 = 6; v.id_rs2 = 6; v.e_stall = 0;
        tbl.push_back(v);
        v.rd = 0; v.e_rd = 0; v.id_rs1 = 0; v.id_rs2 = 6;
        tbl.push_back(v);
        // signed less-than both ways
        tbl.push_back(rr(1, 2, 32'hFFFF_FFFD, 2, 10, 5, 1, 2));
        tbl.push_back(rr(1, 2, 2, 32'hFFFF_FFFD, 10, 5, 0, 32'hFFFF_FFFD));
        // store with rs2 from WB
        v = rr(1, 11, 32'h200, 0, 0, 0, 32'h208, 32'hDEAD_BEEF);
        v.rw = 0; v.e_rw = 0; v.we = 1; v.e_we = 1;
        v.src_imm = 1; v.imm = 8;
        v.wb_we = 1; v.wb_rd = 11; v.wb_data = 32'hDEAD_BEEF;
        tbl.push_back(v);
        // x12 = 7, then A from MEM and B from WB
        tbl.push_back(rr(1, 2, 3, 4, 12, 0, 7, 4));
        v = rr(12, 13, 0, 0, 14, 0, 1007, 1000);
        v.wb_we = 1; v.wb_rd = 13; v.wb_data = 1000;
        tbl.push_back(v);
        // logic ops and an unused code
        tbl.push_back(rr(1, 2, 32'hF0F0, 32'hFF00, 15, 2, 32'hF000, 32'hFF00));
        tbl.push_back(rr(1, 2, 32'hF0F0, 32'hFF00, 15, 3, 32'hFFF0, 32'hFF00));
        tbl.push_back(rr(1, 2, 32'hF0F0, 32'hFF00, 15, 4, 32'h0FF0, 32'hFF00));
        tbl.push_back(rr(1, 2, 32'hF0F0, 32'hFF00, 15, 7, 0, 32'hFF00));
        tbl.push_back(rr(1, 2, 32'h11, 32'h22, 16, 0, 32'h33, 32'h22));

        foreach (tbl[i]) apply(tbl[i], i);

        // hold for three cycles with en=0 and busy inputs
        for (int k = 0; k < 3; k++) begin
            v = rr(1, 2, 9, 9, 20, 0, 32'h33, 32'h22);
            v.en = 0; v.we = 1; v.re = 1; v.m2r = 1;
            v.e_rd = 16;
            apply(v, 100 + k);
        end
        // bubble while stalled clears everything
        v = zero_exp(rr(1, 2, 9, 9, 20, 0, 0, 0));
        v.en = 0; v.bubble = 1; v.we = 1; v.re = 1; v.m2r = 1;
        apply(v, 200);
        // refill, then reset mid-stream
        apply(rr(1, 2, 32'h11, 32'h22, 16, 0, 32'h33, 32'h22), 201);
        v = zero_exp(rr(1, 2, 32'h11, 32'h22, 16, 0, 0, 0));
        v.rst_n = 0;
        apply(v, 202);
        apply(rr(1, 2, 5, 7, 3, 0, 12, 7), 203);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage; sits directly downstream of the ID/EX pipeline register and feeds the MEM stage.
- Resolves RAW hazards by forwarding from its own EX/MEM register and from WB, executes the ALU op on forwarded operands or the immediate, and registers results into the EX/MEM pipeline register.
- Detects load-use hazards against the instruction currently in ID and raises a stall request for the top-level hazard logic.

Parameters:
D_WIDTH, 32, datapath width
N_REGS, 32, register file entries
RF_SIZE, $clog2(N_REGS), register index width
OP_SIZE, 4, ALU op width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; synchronous, active-low
en  in  1  EX/MEM register advance enable
bubble  in  1  insert NOP into EX/MEM register
rs1_ex  in  RF_SIZE  EX source 1 index
rs2_ex  in  RF_SIZE  EX source 2 index
rs1_val_ex  in  D_WIDTH  RF value of rs1
rs2_val_ex  in  D_WIDTH  RF value of rs2
imm_ex  in  D_WIDTH  sign-extended immediate
rd_ex  in  RF_SIZE  destination index
reg_write_ex  in  1  writes rd
alu_src_imm_ex  in  1  operand B = imm_ex
alu_op_ex  in  OP_SIZE  ALU op
mem_we_ex  in  1  store
mem_re_ex  in  1  load
mem_to_reg_ex  in  1  WB selects memory data
id_rs1  in  RF_SIZE  rs1 of instruction in ID
id_rs2  in  RF_SIZE  rs2 of instruction in ID
wb_we  in  1  WB write enable
wb_rd  in  RF_SIZE  WB destination
wb_data  in  D_WIDTH  WB data
alu_result_mem  out  D_WIDTH  registered ALU result / memory address
store_data_mem  out  D_WIDTH  registered forwarded rs2 value
rd_mem  out  RF_SIZE  registered rd
reg_write_mem  out  1  registered reg_write
mem_we_mem  out  1  registered mem_we
mem_re_mem  out  1  registered mem_re
mem_to_reg_mem  out  1  registered mem_to_reg
load_use_stall  out  1  combinational stall request

Behaviour:
- Reset: on a rising clk edge with rst_n=0, every registered output is cleared to 0. Reset overrides bubble and en. load_use_stall is combinational and not reset.
- Forwarding is evaluated independently for operand A (from rs1_ex/rs1_val_ex) and for the rs2 value (from rs2_ex/rs2_val_ex).
  - Priority 1, MEM forward: selects alu_result_mem when reg_write_mem=1, mem_to_reg_mem=0, rd_mem!=0 and rd_mem equals the source index.
  - Priority 2, WB forward: selects wb_data when wb_we=1, wb_rd!=0 and wb_rd equals the source index.
  - Otherwise: the RF value is used.
  - Index 0 never forwards.
- Operand B = imm_ex if alu_src_imm_ex=1, else the forwarded rs2 value. store_data_mem always captures the forwarded rs2 value.
- ALU (combinational, result truncated to D_WIDTH, no overflow flag):
  - 0000: A+B
  - 0001: A-B
  - 0010: A&B
  - 0011: A|B
  - 0100: A^B
  - 0101: signed A<B gives 1, else 0
  - any other code: 0
- EX/MEM register, rising edge, priority order:
  - rst_n=0: clear all registered outputs.
  - Else bubble=1: clear reg_write_mem, mem_we_mem, mem_re_mem and mem_to_reg_mem; data fields are don't-care and are cleared to 0. bubble acts regardless of en.
  - Else en=1: capture the ALU result, forwarded store data, rd_ex and the control bits.
  - Else: hold all fields.
- Latency: 1 cycle from ID/EX register contents to EX/MEM outputs.
- load_use_stall = 1 when all of the following hold, else 0:
  - mem_re_ex=1 and rd_ex!=0;
  - rd_ex equals id_rs1 or id_rs2.
- Top-level response to load_use_stall: hold IF/ID and bubble ID/EX for one cycle. The load then sits in MEM while the dependent instruction waits. The next cycle the load is in WB and its data forwards via wb_data.
- A load result in EX/MEM is never forwarded from MEM, because it is only an address.
- Simultaneous MEM and WB match on the same index: MEM wins.
- Both operands may forward from different sources in the same cycle.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with nonzero inputs -> all *_mem outputs are 0. Release, then present add rs1_val=5, rs2_val=7, alu_op=0000 -> next cycle alu_result_mem=12, reg_write_mem=1.
- MEM forward: issue add x3 with result 12, then sub rs1=x3 with rs1_val_ex=0 and rs2_val=2 -> alu_result_mem=10. Repeat with rd_mem=0 -> no forward.
- Priority: wb_we=1, wb_rd=4, wb_data=100 and simultaneously EX/MEM rd=4 with result 50; EX add x4+imm 1 -> alu_result_mem=51. With EX/MEM mem_to_reg=1 instead -> 101.
- Load-use: mem_re_ex=1, rd_ex=5, id_rs2=5 -> load_use_stall=1. id_rs1=id_rs2=6 -> 0. rd_ex=0 with id_rs1=0 -> 0.
- Store/slt: rs1=-3 (0xFFFFFFFD), rs2=2, alu_op=0101 -> result 1. Store with rs2 forwarded from WB value 0xDEADBEEF, imm=8 -> store_data_mem=0xDEADBEEF, alu_result_mem=rs1+8.
- Stall/flush: en=0 for 3 cycles -> outputs held. bubble=1 with en=0 -> all control bits 0 next cycle. rst_n=0 mid-stream -> cleared next edge.
